// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, next-PC select encoding and reset PC shared by the pipeline
package mips_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_J, NPC_JR} npc_sel_t;
endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC select (jr > j/jal > taken beq > F_PC+4) from D-stage contents; in F_Instr-free ports D_Instr, D_PC, F_PC, D_RD1, D_BrTaken, D_Valid, out npc
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] D_Instr,
  input  logic [31:0] D_PC,
  input  logic [31:0] F_PC,
  input  logic [31:0] D_RD1,
  input  logic        D_BrTaken,
  input  logic        D_Valid,
  output logic [31:0] npc
);
  npc_sel_t sel;
  logic [5:0] op;
  logic [31:0] pc4;
  always_comb begin
    op = D_Instr[31:26];
    pc4 = D_PC + 32'd4;
    sel = !D_Valid ? NPC_SEQ :
          (op == OP_SPECIAL && D_Instr[5:0] == FN_JR) ? NPC_JR :
          (op == OP_J || op == OP_JAL) ? NPC_J :
          (op == OP_BEQ && D_BrTaken) ? NPC_BR : NPC_SEQ;
    npc = sel == NPC_JR ? D_RD1 :
          sel == NPC_J ? {pc4[31:28], D_Instr[25:0], 2'b00} :
          sel == NPC_BR ? pc4 + {{14{D_Instr[15]}}, D_Instr[15:0], 2'b00} :
          F_PC + 32'd4;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register and F/D pipeline register (in clk, rst_n, stall, F_Instr, D_RD1, D_BrTaken; out F_PC, D_Instr, D_PC, D_Valid)
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [31:0] F_Instr,
  input  logic [31:0] D_RD1,
  input  logic        D_BrTaken,
  output logic [31:0] F_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic        D_Valid
);
  logic [31:0] npc;
  npc_calc u_npc (
    .D_Instr(D_Instr),
    .D_PC(D_PC),
    .F_PC(F_PC),
    .D_RD1(D_RD1),
    .D_BrTaken(D_BrTaken),
    .D_Valid(D_Valid),
    .npc(npc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      F_PC <= RESET_PC;
      D_Instr <= NOP;
      D_PC <= 32'd0;
      D_Valid <= 1'b0;
    end else if (!stall) begin
      F_PC <= npc;
      D_Instr <= F_Instr;
      D_PC <= F_PC;
      D_Valid <= 1'b1;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with directed and random stimulus
module tb_fetch_stage;
  logic clk = 0, rst_n = 0, stall = 0, D_BrTaken = 0;
  logic [31:0] F_Instr = 0, D_RD1 = 0;
  logic [31:0] F_PC, D_Instr, D_PC;
  logic D_Valid;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [31:0] pc, di, dpc; logic dv;} st_t;
  st_t exp_q[$];
  st_t e_mon;
  logic [31:0] m_pc, m_di, m_dpc;
  logic m_dv;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .F_Instr(F_Instr), .D_RD1(D_RD1),
    .D_BrTaken(D_BrTaken), .F_PC(F_PC), .D_Instr(D_Instr), .D_PC(D_PC), .D_Valid(D_Valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (exp_q.size() > 0) begin
      e_mon = exp_q.pop_front();
      vectors++;
      if ({F_PC, D_Instr, D_PC, D_Valid} !== e_mon) begin
        miscompares++;
        $display("FAIL state: got pc=%h di=%h dpc=%h dv=%b, want pc=%h di=%h dpc=%h dv=%b",
                 F_PC, D_Instr, D_PC, D_Valid, e_mon.pc, e_mon.di, e_mon.dpc, e_mon.dv);
      end
    end

  function automatic logic [31:0] model_npc(logic [31:0] pc, di, dpc, logic dv, logic [31:0] rd1, logic bt);
    logic [5:0] op = di[31:26];
    if (!dv) return pc + 4;
    if (op == 6'd0 && di[5:0] == 6'd8) return rd1;
    if (op == 6'd2 || op == 6'd3) return ((dpc + 4) & 32'hF000_0000) | ({6'd0, di[25:0]} * 4);
    if (op == 6'd4 && bt) return dpc + 4 + {{16{di[15]}}, di[15:0]} * 4;
    return pc + 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic [31:0] fi, rd1, input logic bt);
    logic [31:0] nxt;
    stall = s; F_Instr = fi; D_RD1 = rd1; D_BrTaken = bt;
    if (!s) begin
      nxt = model_npc(m_pc, m_di, m_dpc, m_dv, rd1, bt);
      m_dpc = m_pc; m_di = fi; m_dv = 1; m_pc = nxt;
    end
    @(posedge clk);
    exp_q.push_back({m_pc, m_di, m_dpc, m_dv});
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 0; stall = 0; F_Instr = 0; D_BrTaken = 0;
    m_pc = 32'h3000; m_di = 0; m_dpc = 0; m_dv = 0;
    #1;
    chk("reset_pc", F_PC, 32'h3000);
    chk("reset_valid", {31'd0, D_Valid}, 32'd0);
    exp_q.push_back({m_pc, m_di, m_dpc, m_dv});
    @(negedge clk); #1;
    rst_n = 1;
  endtask

  localparam logic [31:0] BEQ3 = 32'h1000_0003, BEQ_NEG = 32'h1000_FFFF;
  localparam logic [31:0] JAL = 32'h0C00_0C10, JR = 32'h03E0_0008, SLOT = 32'h2001_0005;

  initial begin
    do_reset();
    step(0, 0, 0, 0);
    chk("post_reset_pc", F_PC, 32'h3004);
    chk("post_reset_dpc", D_PC, 32'h3000);
    chk("post_reset_valid", {31'd0, D_Valid}, 32'd1);
    step(0, 0, 0, 0); chk("seq_pc1", F_PC, 32'h3008);
    step(0, 0, 0, 0); chk("seq_pc2", F_PC, 32'h300C);
    step(1, SLOT, 0, 0); step(1, SLOT, 0, 0);
    chk("stall_pc", F_PC, 32'h300C);
    chk("stall_dpc", D_PC, 32'h3008);
    chk("stall_di", D_Instr, 32'h0);
    step(0, 0, 0, 0);
    step(0, BEQ3, 0, 0);
    chk("beq_dpc", D_PC, 32'h3010);
    step(0, SLOT, 0, 1);
    chk("beq_taken_pc", F_PC, 32'h3020);
    chk("delay_slot_di", D_Instr, SLOT);
    chk("delay_slot_dpc", D_PC, 32'h3014);
    do_reset();
    repeat (4) step(0, 0, 0, 0);
    step(0, BEQ3, 0, 0);
    step(0, SLOT, 0, 0);
    chk("beq_not_taken_pc", F_PC, 32'h3018);
    do_reset();
    step(0, JAL, 0, 0);
    step(0, SLOT, 0, 0);
    chk("jal_pc", F_PC, 32'h3040);
    do_reset();
    step(0, JR, 0, 0);
    step(0, SLOT, 32'h0, 0);
    chk("jr_zero_pc", F_PC, 32'h0);
    step(0, BEQ_NEG, 0, 0);
    chk("wrap_dpc", D_PC, 32'h0);
    step(0, SLOT, 0, 1);
    chk("beq_wrap_pc", F_PC, 32'h0);
    do_reset();
    step(0, JR, 0, 0);
    step(1, SLOT, 32'h3100, 0);
    chk("jr_stall_pc", F_PC, 32'h3004);
    step(0, SLOT, 32'h3100, 0);
    chk("jr_pc", F_PC, 32'h3100);
    do_reset();
    step(1, BEQ3, 0, 1);
    chk("bubble_stall_valid", {31'd0, D_Valid}, 32'd0);
    chk("bubble_stall_pc", F_PC, 32'h3000);
    step(0, SLOT, 0, 1);
    chk("bubble_release_pc", F_PC, 32'h3004);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] fi;
      case ($urandom_range(0, 4))
        0: fi = {6'd4, 10'($urandom), 16'($urandom)};
        1: fi = {6'd2, 26'($urandom)};
        2: fi = {6'd3, 26'($urandom)};
        3: fi = {6'd0, 20'($urandom), 6'd8};
        default: fi = $urandom;
      endcase
      if ($urandom_range(0, 63) == 0) do_reset();
      step($urandom_range(0, 3) == 0, fi, $urandom, 1'($urandom));
    end
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

- Owns the PC register, next-PC selection and the F/D pipeline register of the five-stage MIPS pipeline.
- Upstream of the hazard unit: it produces the D-stage instruction and PC, and it obeys the hazard unit's stall (PC/D-register hold).
- Branch and jump targets are resolved in D from the held D-stage instruction, with one architectural delay slot and no flush on a taken branch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC value after reset.
- `NOP`, 32'h0000_0000: instruction word placed in D on reset.

Ports:
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: 1 holds the PC and the F/D register. Driven as the inverse of the hazard unit's PC/D enable.
- `F_Instr`  in  32: instruction word read combinationally from IM at `F_PC`.
- `D_RD1`  in  32: forwarded rs value in D, used as the jr target.
- `D_BrTaken`  in  1: D-stage comparator result for the branch held in D.
- `F_PC`  out  32: current fetch address, driven to IM.
- `D_Instr`  out  32: F/D register instruction.
- `D_PC`  out  32: F/D register PC.
- `D_Valid`  out  1: 0 while D holds the reset bubble; 1 once a fetched instruction has entered D.

## Operation
Next-PC source is decoded from `D_Instr` opcode/funct, in this priority:
- **jr** (op 000000, funct 001000) → `D_RD1`.
- **j / jal** (op 000010 / 000011) → `{D_PC[31:28] + carry-free of D_PC+4, D_Instr[25:0], 2'b00}`. Concretely, bits 31:28 come from (`D_PC`+4).
- **beq** (op 000100) with `D_BrTaken`=1 → `D_PC + 4 + (sext(D_Instr[15:0]) << 2)`.
- **Otherwise** → `F_PC + 4`.

Arithmetic rules:
- All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- Target computation only looks at `D_Valid`=1 contents. When `D_Valid`=0, the next PC is always `F_PC+4`.

Register updates per rising edge:
- **`stall`=0:** `F_PC`←next-PC; `D_Instr`←`F_Instr`; `D_PC`←`F_PC`; `D_Valid`←1.
- **`stall`=1:** `F_PC`, `D_Instr`, `D_PC` and `D_Valid` all hold, and the redirect is suppressed. The branch in D is re-evaluated next cycle with fresh forwarded operands.

Two-state control, encoded by `D_Valid`:
- **BUBBLE** (after reset) → FILL on the first non-stalled edge.
- **FILL** stays FILL until reset.

Boundary conditions:
- A stall during BUBBLE keeps BUBBLE.
- The delay slot is the instruction at `D_PC+4`. It is in F when the redirect happens and always enters D; it is never squashed.
- `stall` and `D_BrTaken` high together → hold; the stall wins.
- `rst_n` asserted mid-operation: all registers return to reset values immediately. The in-flight F and D contents are discarded.
- Misaligned `D_RD1` on jr: loaded into PC unchanged. No checking is done in this block.

## Timing
Reset values (asynchronous, while `rst_n`=0):
- `F_PC`=`RESET_PC`
- `D_Instr`=`NOP`
- `D_PC`=0
- `D_Valid`=0

Latency and paths:
- Fetch-to-D latency is 1 cycle.
- Redirect latency: a target resolved in cycle n appears on `F_PC` in cycle n+1, so exactly one delay-slot instruction is fetched.
- Combinational paths:
  - `D_RD1` and `D_BrTaken` → next-PC → PC register D-input.
  - `F_PC` → IM → `F_Instr` → F/D D-input.
- No output is combinational from any input. All outputs are register outputs.

## Structure
- Shared package `mips_pkg`:
  - opcode/funct constants: `OP_SPECIAL`, `OP_BEQ`, `OP_J`, `OP_JAL`, `FN_JR`.
  - 2-bit `npc_sel_t` enum: `NPC_SEQ`, `NPC_BR`, `NPC_J`, `NPC_JR`.
  - `RESET_PC` default.
- One sub-module `npc_calc`: purely combinational target/select logic from `D_Instr`, `D_PC`, `F_PC`, `D_RD1`, `D_BrTaken` and `D_Valid`. The top holds the PC and F/D registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → `F_PC`=0x3000, `D_Instr`=0, `D_Valid`=0 immediately. Release with `stall`=0 → next edge `F_PC`=0x3004, `D_PC`=0x3000, `D_Valid`=1.
- **Sequential with stall:** 3 edges with `stall`=0 → `F_PC` 0x3004→0x3008→0x300C. Then hold `stall`=1 for 2 edges → `F_PC`, `D_Instr` and `D_PC` are unchanged.
- **Taken beq:** `D_PC`=0x3010, imm=0x0003, `D_BrTaken`=1 → next `F_PC`=0x3020, and the delay slot fetched at 0x3014 enters D. With `D_BrTaken`=0 → `F_PC`=0x3018.
- **jal:** `D_PC`=0x3000, index=0x0000C10 → next `F_PC`=0x0000_3040. Also check negative branch wrap: `D_PC`=0x0, imm=0xFFFF → `F_PC`=0x0.
- **jr with stall:** `D_RD1`=0x3100 and `stall`=1 → PC holds. `stall` drops the next cycle → `F_PC`=0x3100.
- **Stall during BUBBLE:** `stall`=1 right after reset → `D_Valid` stays 0 and a branch-shaped `F_Instr` causes no redirect. Then `stall`=0 → `F_PC`=0x3004.
